aes_encrypt_core: RTL and testbench

//  Iterative AES-128 encryption core: plaintext + key in, ciphertext out, start/done handshake.

---
 rtl/aes_encrypt_core_if.sv | 20 ++
 rtl/aes_encrypt_core.sv | 198 +++++++++++++++++++
 tb/tb_aes_encrypt_core.sv | 129 ++++++++++++
 3 files changed

// File: rtl/aes_encrypt_core_if.sv
// Handshake/data bundle for aes_encrypt_core.
// The controller drives through the master modport and the core attaches to the slave modport.
interface aes_encrypt_core_if;
   logic         AES_START;
   logic [127:0] AES_KEY;
   logic [127:0] AES_MSG_DEC;
   logic         AES_DONE;
   logic         AES_BUSY;
   logic [127:0] AES_MSG_ENC;

   modport master (
      output AES_START, AES_KEY, AES_MSG_DEC,
      input  AES_DONE, AES_BUSY, AES_MSG_ENC
   );

   modport slave (
      input  AES_START, AES_KEY, AES_MSG_DEC,
      output AES_DONE, AES_BUSY, AES_MSG_ENC
   );
endinterface

// File: rtl/aes_encrypt_core.sv
// aes_encrypt_core: iterative AES-128 encryption with a start/done handshake.
// Byte s(0,0) sits in bits [127:120], and column c sits in bits [127-32c -: 32].
// Optional build macro AES_ENC_FULL_MIX_EN: MixColumns runs on all four columns in one cycle.
// Without the macro, one MixColumns unit processes one column per cycle.
module aes_encrypt_core #(
   parameter int unsigned KEY_WAIT = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   aes_encrypt_core_if.slave aes_bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_KWAIT, S_ARK0, S_SUB, S_SUBW, S_SHIFT, S_MIX, S_ARK, S_DONE
   } fsm_t;

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };
   localparam logic [79:0] RCON_TBL = 80'h01020408102040801b36;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[2047 - 8*int'(b) -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int unsigned i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
      return r;
   endfunction

   // Row r of the output column c is taken from input column (c+r) mod 4, which rotates row r left by r bytes.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int unsigned c = 0; c < 4; c++)
         for (int unsigned w = 0; w < 4; w++)
            r[127 - 32*c - 8*w -: 8] = s[127 - 32*((c + w) % 4) - 8*w -: 8];
      return r;
   endfunction

   function automatic logic [127:0] key_step(input logic [127:0] w, input logic [7:0] rc);
      logic [31:0] t, n0, n1, n2, n3;
      t  = {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])} ^ {rc, 24'h0};
      n0 = w[127:96] ^ t;
      n1 = w[95:64]  ^ n0;
      n2 = w[63:32]  ^ n1;
      n3 = w[31:0]   ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   fsm_t         fsm_q, fsm_d;
   logic [127:0] st_q, st_d;
   logic [127:0] sub_q, sub_d;
   logic [127:0] key_q, key_d;
   logic [127:0] enc_q, enc_d;
   logic [3:0]   round_q, round_d;
   logic [1:0]   col_q, col_d;
   logic [7:0]   cnt_q, cnt_d;
   logic [1407:0] sched;
   logic [127:0] rk;
   logic         done, busy;

   // The key schedule is expanded combinationally from the captured key, and KWAIT covers its settling time.
   assign sched[127:0] = key_q;
   for (genvar r = 1; r <= 10; r++) begin : g_sched
      assign sched[128*r +: 128] = key_step(sched[128*(r-1) +: 128], RCON_TBL[8*(10-r) +: 8]);
   end

   // Select the round key; rounds outside 0..10 give zero and cannot occur.
   always_comb begin
      rk = '0;
      if (round_q <= 4'd10) rk = sched[128*int'(round_q) +: 128];
   end

   // FSM state register
   always_ff @(posedge CLK) begin
      if (RESET) fsm_q <= S_IDLE;
      else       fsm_q <= fsm_d;
   end

   // FSM next-state logic
   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         S_IDLE:  if (aes_bus.AES_START) fsm_d = S_LOAD;
         S_LOAD:  fsm_d = S_KWAIT;
         S_KWAIT: if (cnt_q == 8'd0) fsm_d = S_ARK0;
         S_ARK0:  fsm_d = S_SUB;
         S_SUB:   fsm_d = S_SUBW;
         S_SUBW:  fsm_d = S_SHIFT;
         S_SHIFT: fsm_d = (round_q == 4'd10) ? S_ARK : S_MIX;
`ifdef AES_ENC_FULL_MIX_EN
         S_MIX:   fsm_d = S_ARK;
`else
         S_MIX:   if (col_q == 2'd3) fsm_d = S_ARK;
`endif
         S_ARK:   fsm_d = (round_q == 4'd10) ? S_DONE : S_SUB;
         S_DONE:  if (!aes_bus.AES_START) fsm_d = S_IDLE;
         default: fsm_d = S_IDLE;
      endcase
   end

   // FSM outputs are decoded from the state register.
   always_comb begin
      done = (fsm_q == S_DONE);
      busy = (fsm_q != S_IDLE) && (fsm_q != S_DONE);
   end

   assign aes_bus.AES_DONE    = done;
   assign aes_bus.AES_BUSY    = busy;
   assign aes_bus.AES_MSG_ENC = enc_q;

   // Datapath next-state logic for each FSM step
   always_comb begin
      st_d    = st_q;
      sub_d   = sub_q;
      key_d   = key_q;
      enc_d   = enc_q;
      round_d = round_q;
      col_d   = col_q;
      cnt_d   = cnt_q;
      case (fsm_q)
         S_LOAD: begin
            st_d    = aes_bus.AES_MSG_DEC;
            key_d   = aes_bus.AES_KEY;
            round_d = 4'd0;
            col_d   = 2'd0;
            cnt_d   = 8'(KEY_WAIT);
         end
         S_KWAIT: if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
         S_ARK0: begin
            st_d    = st_q ^ rk;
            round_d = 4'd1;
         end
         S_SUB:   sub_d = sub_bytes(st_q);
         S_SUBW:  st_d  = sub_q;
         S_SHIFT: st_d  = shift_rows(st_q);
         S_MIX: begin
`ifdef AES_ENC_FULL_MIX_EN
            for (int unsigned c = 0; c < 4; c++) st_d[32*c +: 32] = mix_col(st_q[32*c +: 32]);
`else
            st_d[32*(3 - int'(col_q)) +: 32] = mix_col(st_q[32*(3 - int'(col_q)) +: 32]);
            col_d = col_q + 2'd1;
`endif
         end
         S_ARK: begin
            st_d = st_q ^ rk;
            if (round_q == 4'd10) enc_d = st_q ^ rk;
            else                  round_d = round_q + 4'd1;
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         st_q    <= '0;
         sub_q   <= '0;
         key_q   <= '0;
         enc_q   <= '0;
         round_q <= '0;
         col_q   <= '0;
         cnt_q   <= '0;
      end else begin
         st_q    <= st_d;
         sub_q   <= sub_d;
         key_q   <= key_d;
         enc_q   <= enc_d;
         round_q <= round_d;
         col_q   <= col_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Scoreboard bench for aes_encrypt_core using FIPS-197 vectors, a handshake hold, input changes during a run, and reset abort.
module tb_aes_encrypt_core;

   localparam int unsigned KW = 2;
`ifdef AES_ENC_FULL_MIX_EN
   localparam int unsigned LAT = 52 + KW;
`else
   localparam int unsigned LAT = 79 + KW;
`endif

   localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] C_ZRO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;
   logic [127:0] exp_q[$];

   always #5 clk = ~clk;

   aes_encrypt_core_if bus();

   aes_encrypt_core #(.KEY_WAIT(KW)) dut (
      .CLK     (clk),
      .RESET   (rst),
      .aes_bus (bus)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Runs one encryption. poke: at edge 5, set the inputs to all-ones and drop START. hold: keep START high for 200 cycles in DONE.
   task automatic run_vec(input string tag, input logic [127:0] key, input logic [127:0] pt,
                          input logic [127:0] exp, input bit poke, input bit hold);
      int unsigned k;
      int unsigned bad;
      bit seen;
      logic [127:0] want;
      @(negedge clk);
      bus.AES_KEY     = key;
      bus.AES_MSG_DEC = pt;
      bus.AES_START   = 1'b1;
      exp_q.push_back(exp);
      seen = 1'b0;
      k    = 0;
      for (int unsigned e = 0; e < 400 && !seen; e++) begin
         @(posedge clk); #1;
         if (poke && e == 5) begin
            bus.AES_KEY     = '1;
            bus.AES_MSG_DEC = '1;
            bus.AES_START   = 1'b0;
         end
         if (e == 10) check({tag, "_busy_mid"}, 128'(bus.AES_BUSY), 128'd1);
         if (bus.AES_DONE) begin
            seen = 1'b1;
            k    = e;
         end
      end
      check({tag, "_done_edge"}, 128'(k), 128'(LAT));
      want = exp_q.pop_front();
      check({tag, "_ct"}, bus.AES_MSG_ENC, want);
      if (hold) begin
         bad = 0;
         repeat (200) begin
            @(posedge clk); #1;
            if (bus.AES_DONE !== 1'b1 || bus.AES_BUSY !== 1'b0 || bus.AES_MSG_ENC !== want) bad++;
         end
         check({tag, "_hold_glitches"}, 128'(bad), 128'd0);
      end
      @(negedge clk);
      bus.AES_START = 1'b0;
      @(posedge clk); #1;
      check({tag, "_done_after"}, 128'(bus.AES_DONE), 128'd0);
      check({tag, "_busy_after"}, 128'(bus.AES_BUSY), 128'd0);
   endtask

   initial begin
      rst             = 1'b1;
      bus.AES_START   = 1'b0;
      bus.AES_KEY     = '0;
      bus.AES_MSG_DEC = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_done", 128'(bus.AES_DONE), 128'd0);
      check("rst_busy", 128'(bus.AES_BUSY), 128'd0);
      check("rst_enc",  bus.AES_MSG_ENC, 128'd0);
      @(negedge clk);
      rst = 1'b0;

      run_vec("c1",      K_C1, P_C1, C_C1,  1'b0, 1'b0);
      run_vec("b_hold",  K_B,  P_B,  C_B,   1'b0, 1'b1);
      run_vec("zero",    '0,   '0,   C_ZRO, 1'b0, 1'b0);
      run_vec("c1_poke", K_C1, P_C1, C_C1,  1'b1, 1'b0);

      // Abort a C.1 run with a reset sampled at edge 40.
      @(negedge clk);
      bus.AES_KEY     = K_C1;
      bus.AES_MSG_DEC = P_C1;
      bus.AES_START   = 1'b1;
      for (int unsigned e = 0; e < 40; e++) begin
         @(posedge clk); #1;
      end
      rst           = 1'b1;
      bus.AES_START = 1'b0;
      @(posedge clk); #1;
      check("abort_busy", 128'(bus.AES_BUSY), 128'd0);
      check("abort_done", 128'(bus.AES_DONE), 128'd0);
      check("abort_enc",  bus.AES_MSG_ENC, 128'd0);
      @(negedge clk);
      rst = 1'b0;

      run_vec("b_after", K_B, P_B, C_B, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
